// File: rtl/router_pkt_tx_pkg.sv
// Shared router definitions: FSM encoding, header layout and payload pattern helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package router_pkt_tx_pkg;

    localparam int ADDR_W = 2;
    localparam int LEN_W  = 6;
    localparam int BYTE_W = 8;

    // Destination 3 does not exist on the 1x3 router.
    localparam logic [ADDR_W-1:0] ILLEGAL_ADDR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_PARITY  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Header byte as seen on the wire: length in the upper bits, address in the lower.
    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [ADDR_W-1:0] addr;
    } hdr_t;

    // Payload byte i is seed + i, wrapping mod 256.
    function automatic logic [BYTE_W-1:0] payload_byte(input logic [BYTE_W-1:0] seed,
                                                       input logic [LEN_W-1:0]  idx);
        return seed + {{(BYTE_W-LEN_W){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/router_parity_acc.sv
// XOR parity accumulator with synchronous clear, enable and invert-on-read.
// Latency: accumulate takes effect on the next rising edge; read path is combinational.
// Backpressure: none; the caller gates en so held bytes are folded in only once.
module router_parity_acc
    import router_pkt_tx_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [BYTE_W-1:0] din,
    input  logic              inv,
    output logic [BYTE_W-1:0] parity
);

    logic [BYTE_W-1:0] acc;

    // Clear wins over accumulate so a new packet always starts from zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc ^ din;
        end
    end

    assign parity = inv ? ~acc : acc;

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet transmitter: header, incrementing payload, parity byte per start.
// Latency: header appears the cycle after an accepted start; len+2 cycles per packet with no busy.
// Backpressure: busy holds the current byte; BUSY_TO consecutive busy cycles abort the packet.
module router_pkt_tx
    import router_pkt_tx_pkg::*;
#(
    parameter int MAX_LEN = 63,
    parameter int GAP     = 2,
    parameter int BUSY_TO = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic [LEN_W-1:0]  payload_len,
    input  logic [BYTE_W-1:0] seed,
    input  logic              corrupt_parity,
    input  logic              busy,
    output logic              ready,
    output logic              pkt_valid,
    output logic [BYTE_W-1:0] data_in,
    output logic              done,
    output logic              err
);

    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int BTO_W = $clog2(BUSY_TO + 1);

    state_t            state, next_state;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx_q;
    logic [BYTE_W-1:0] seed_q;
    logic              corrupt_q;
    logic [BTO_W-1:0]  busy_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              err_q;

    logic              active;
    logic              req_legal;
    logic              start_ok;
    logic              start_bad;
    logic              timeout;
    logic              acc_clr;
    logic              acc_en;
    logic [BYTE_W-1:0] acc_din;
    logic [BYTE_W-1:0] parity;
    logic [BYTE_W-1:0] pay_byte;
    hdr_t              hdr;

    assign active    = (state == ST_HEADER) || (state == ST_PAYLOAD) || (state == ST_PARITY);
    assign req_legal = (dest_addr != ILLEGAL_ADDR) &&
                       (payload_len != '0) &&
                       (payload_len <= LEN_W'(MAX_LEN));
    assign hdr.len   = len_q;
    assign hdr.addr  = addr_q;
    assign pay_byte  = payload_byte(seed_q, idx_q);
    assign err       = err_q;

    router_parity_acc u_parity (
        .clock  (clock),
        .reset  (reset),
        .clr    (acc_clr),
        .en     (acc_en),
        .din    (acc_din),
        .inv    (corrupt_q),
        .parity (parity)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, wire outputs and accumulator control; nothing advances while busy.
    always_comb begin
        next_state = state;
        ready      = 1'b0;
        pkt_valid  = 1'b0;
        data_in    = '0;
        done       = 1'b0;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        acc_din    = '0;
        start_ok   = 1'b0;
        start_bad  = 1'b0;
        timeout    = 1'b0;

        case (state)
            ST_IDLE: begin
                ready = (gap_cnt == '0);
                if (ready && start) begin
                    if (req_legal) begin
                        start_ok   = 1'b1;
                        acc_clr    = 1'b1;
                        next_state = ST_HEADER;
                    end else begin
                        start_bad  = 1'b1;
                    end
                end
            end
            ST_HEADER: begin
                pkt_valid = 1'b1;
                data_in   = hdr;
                if (!busy) begin
                    acc_en     = 1'b1;
                    acc_din    = hdr;
                    next_state = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                pkt_valid = 1'b1;
                data_in   = pay_byte;
                if (!busy) begin
                    acc_en  = 1'b1;
                    acc_din = pay_byte;
                    if (idx_q == len_q - LEN_W'(1)) begin
                        next_state = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                data_in = parity;
                if (!busy) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        // A stalled router gets BUSY_TO cycles before the packet is dropped.
        if (active && busy && (busy_cnt == BTO_W'(BUSY_TO - 1))) begin
            timeout    = 1'b1;
            next_state = ST_IDLE;
        end
    end

    // Capture the request fields so the inputs may change once the packet is under way.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            len_q     <= '0;
            seed_q    <= '0;
            corrupt_q <= 1'b0;
        end else if (start_ok) begin
            addr_q    <= dest_addr;
            len_q     <= payload_len;
            seed_q    <= seed;
            corrupt_q <= corrupt_parity;
        end
    end

    // Payload index: restarts per packet, advances only on an accepted payload byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
        end else if (start_ok) begin
            idx_q <= '0;
        end else if ((state == ST_PAYLOAD) && !busy) begin
            idx_q <= idx_q + LEN_W'(1);
        end
    end

    // Consecutive-busy counter; any idle-router cycle or leaving the packet clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_cnt <= '0;
        end else if (active && busy && !timeout) begin
            busy_cnt <= busy_cnt + BTO_W'(1);
        end else begin
            busy_cnt <= '0;
        end
    end

    // Inter-packet gap: loaded on completion or abort, then counts down to zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gap_cnt <= '0;
        end else if ((state == ST_DONE) || timeout) begin
            gap_cnt <= GAP_W'(GAP);
        end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

    // Error pulse for a rejected request or a busy timeout, one cycle after the event.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= start_bad || timeout;
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
module tb_router_pkt_tx;

    localparam logic [1:0] K_BYTE = 2'd0;
    localparam logic [1:0] K_PAR  = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;
    localparam logic [1:0] K_ERR  = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] val;
    } ev_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] dest_addr = 2'd0;
    logic [5:0] payload_len = 6'd0;
    logic [7:0] seed = 8'd0;
    logic       corrupt_parity = 1'b0;
    logic       busy = 1'b0;
    logic       ready;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       done;
    logic       err;

    int  tests = 0;
    int  fails = 0;
    ev_t sb[$];
    bit  in_pkt = 1'b0;

    router_pkt_tx dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .dest_addr      (dest_addr),
        .payload_len    (payload_len),
        .seed           (seed),
        .corrupt_parity (corrupt_parity),
        .busy           (busy),
        .ready          (ready),
        .pkt_valid      (pkt_valid),
        .data_in        (data_in),
        .done           (done),
        .err            (err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic expect_ev(input logic [1:0] k, input logic [7:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic got(input logic [1:0] k, input logic [7:0] v);
        ev_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: got kind %0d data %h, expected no event", k, v);
        end else begin
            e = sb.pop_front();
            if (e.kind !== k || e.val !== v) begin
                fails++;
                $display("FAIL sb_event: got kind %0d data %h, expected kind %0d data %h",
                         k, v, e.kind, e.val);
            end
        end
    endtask

    // Router-side monitor: records every accepted byte, parity byte, done and err pulse.
    always @(negedge clock) begin
        if (reset) begin
            in_pkt = 1'b0;
        end else begin
            if (pkt_valid && !busy) begin
                got(K_BYTE, data_in);
                in_pkt = 1'b1;
            end else if (in_pkt && !pkt_valid && !busy && !err && !done) begin
                got(K_PAR, data_in);
                in_pkt = 1'b0;
            end
            if (done) got(K_DONE, 8'h00);
            if (err) begin
                got(K_ERR, 8'h00);
                in_pkt = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [1:0] a, input logic [5:0] l, input logic [7:0] s,
                        input logic cp, input int hb);
        int n;
        n = 0;
        tick();
        while (!ready && n < 50) begin
            tick();
            n++;
        end
        chk("ready_before_start", 32'(ready), 32'd1);
        dest_addr      = a;
        payload_len    = l;
        seed           = s;
        corrupt_parity = cp;
        start          = 1'b1;
        tick();
        start = 1'b0;
        if (hb > 0) begin
            busy = 1'b1;
            repeat (hb) tick();
            busy = 1'b0;
        end
    endtask

    task automatic wait_done(input string name, output int cyc);
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (!done && cyc < 300);
        chk(name, 32'(done), 32'd1);
    endtask

    task automatic check_gap(input string name);
        @(negedge clock);
        chk({name, "_gap1"}, 32'(ready), 32'd0);
        @(negedge clock);
        chk({name, "_gap2"}, 32'(ready), 32'd0);
        @(negedge clock);
        chk({name, "_ready"}, 32'(ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        // Reset values, checked while reset is held and after release.
        #3;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_pkt_valid", 32'(pkt_valid), 32'd0);
        chk("rst_data_in", 32'(data_in), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_ready", 32'(ready), 32'd1);
        chk("post_rst_pkt_valid", 32'(pkt_valid), 32'd0);

        // addr=1 len=3 seed=10: header 0D, parity 0D^10^11^12 = 1E.
        expect_ev(K_BYTE, 8'h0D); expect_ev(K_BYTE, 8'h10);
        expect_ev(K_BYTE, 8'h11); expect_ev(K_BYTE, 8'h12);
        expect_ev(K_PAR, 8'h1E);  expect_ev(K_DONE, 8'h00);
        send(2'd1, 6'd3, 8'h10, 1'b0, 0);
        wait_done("p1_done", cyc);
        chk("p1_duration", 32'(cyc), 32'd6);
        check_gap("p1");

        // Same packet, busy for 3 cycles while the second payload byte (11) is driven.
        expect_ev(K_BYTE, 8'h0D); expect_ev(K_BYTE, 8'h10);
        expect_ev(K_BYTE, 8'h11); expect_ev(K_BYTE, 8'h12);
        expect_ev(K_PAR, 8'h1E);  expect_ev(K_DONE, 8'h00);
        send(2'd1, 6'd3, 8'h10, 1'b0, 0);
        tick();
        tick();
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("p2_hold_data", 32'(data_in), 32'h11);
            chk("p2_hold_valid", 32'(pkt_valid), 32'd1);
            tick();
        end
        busy = 1'b0;
        @(negedge clock);
        chk("p2_hold_last", 32'(data_in), 32'h11);
        wait_done("p2_done", cyc);

        // Busy from HEADER entry for 3 cycles: header 04 sent once, parity 04^80 = 84.
        expect_ev(K_BYTE, 8'h04); expect_ev(K_BYTE, 8'h80);
        expect_ev(K_PAR, 8'h84);  expect_ev(K_DONE, 8'h00);
        send(2'd0, 6'd1, 8'h80, 1'b0, 3);
        wait_done("hb3_done", cyc);

        // 63 busy cycles is one short of the timeout: packet completes (06, 00, parity 06).
        expect_ev(K_BYTE, 8'h06); expect_ev(K_BYTE, 8'h00);
        expect_ev(K_PAR, 8'h06);  expect_ev(K_DONE, 8'h00);
        send(2'd2, 6'd1, 8'h00, 1'b0, 63);
        wait_done("hb63_done", cyc);

        // Illegal address and illegal length: err next cycle, ready stays high.
        expect_ev(K_ERR, 8'h00);
        send(2'd3, 6'd5, 8'h00, 1'b0, 0);
        @(negedge clock);
        chk("ill_addr_err", 32'(err), 32'd1);
        chk("ill_addr_ready", 32'(ready), 32'd1);
        chk("ill_addr_valid", 32'(pkt_valid), 32'd0);
        expect_ev(K_ERR, 8'h00);
        send(2'd0, 6'd0, 8'h00, 1'b0, 0);
        @(negedge clock);
        chk("ill_len_err", 32'(err), 32'd1);
        chk("ill_len_ready", 32'(ready), 32'd1);

        // 64 busy cycles in HEADER: abort, no parity, gap before ready.
        expect_ev(K_ERR, 8'h00);
        send(2'd1, 6'd4, 8'h20, 1'b0, 64);
        @(negedge clock);
        chk("to_err", 32'(err), 32'd1);
        chk("to_valid", 32'(pkt_valid), 32'd0);
        chk("to_ready", 32'(ready), 32'd0);
        @(negedge clock);
        chk("to_err_pulse", 32'(err), 32'd0);
        chk("to_gap", 32'(ready), 32'd0);
        @(negedge clock);
        chk("to_ready_back", 32'(ready), 32'd1);

        // addr=2 len=2 seed=FF corrupt: 0A, FF, 00, parity ~(0A^FF^00) = 0A.
        expect_ev(K_BYTE, 8'h0A); expect_ev(K_BYTE, 8'hFF);
        expect_ev(K_BYTE, 8'h00); expect_ev(K_PAR, 8'h0A);
        expect_ev(K_DONE, 8'h00);
        send(2'd2, 6'd2, 8'hFF, 1'b1, 0);
        wait_done("p5_done", cyc);

        // Start raised only during the gap cycles is ignored.
        tick();
        dest_addr   = 2'd0;
        payload_len = 6'd1;
        start       = 1'b1;
        tick();
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("gap_start_ignored", 32'(pkt_valid), 32'd0);

        // Reset mid-PAYLOAD: header 28 and first byte 40 accepted, then abandoned.
        expect_ev(K_BYTE, 8'h28); expect_ev(K_BYTE, 8'h40);
        send(2'd0, 6'd10, 8'h40, 1'b0, 0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(pkt_valid), 32'd0);
        chk("mid_rst_data", 32'(data_in), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd1);
        repeat (2) tick();
        reset = 1'b0;
        chk("mid_rst_sb_drained", 32'(sb.size()), 32'd0);

        // Clean packet after reset: 05, 5A, parity 05^5A = 5F.
        expect_ev(K_BYTE, 8'h05); expect_ev(K_BYTE, 8'h5A);
        expect_ev(K_PAR, 8'h5F);  expect_ev(K_DONE, 8'h00);
        send(2'd1, 6'd1, 8'h5A, 1'b0, 0);
        wait_done("post_rst_done", cyc);
        check_gap("post_rst");

        repeat (4) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
